pu_rmw_sched: RTL and testbench

PU_RMW_SCHED -- requirements
Module: pu_rmw_sched

---
 rtl/pu_rmw_sched.sv | 164 ++++++++++++++++
 tb/tb_pu_rmw_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_rmw_sched.sv
// Shared-RAM access scheduler: independent round-robin read and write arbiters plus a
// three-stage address lock that serialises atomic read-modify-write against other traffic.
module pu_rmw_sched #(
    parameter int NUM_REQ    = 8,
    parameter int ADDR_NBITS = 12,
    parameter int ID_NBITS   = 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ-1:0]            req_atomic,
    input  logic [NUM_REQ*ADDR_NBITS-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          rd_en,
    output logic [ADDR_NBITS-1:0]         rd_addr,
    output logic [ID_NBITS-1:0]           rd_sel,
    output logic                          wr_en,
    output logic [ADDR_NBITS-1:0]         wr_addr,
    output logic [ID_NBITS-1:0]           wr_sel,
    output logic                          wr_wb
);

    logic [ADDR_NBITS-1:0] addr_a [NUM_REQ];

    logic [NUM_REQ-1:0]    gnt_q,     gnt_d;
    logic [ID_NBITS-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [ID_NBITS-1:0]   wr_ptr_q,  wr_ptr_d;
    logic                  s1_vld_q,  s1_vld_d;
    logic [ADDR_NBITS-1:0] s1_addr_q, s1_addr_d;
    logic [ID_NBITS-1:0]   s1_id_q,   s1_id_d;
    logic                  s2_vld_q,  s2_vld_d;
    logic [ADDR_NBITS-1:0] s2_addr_q, s2_addr_d;
    logic [ID_NBITS-1:0]   s2_id_q,   s2_id_d;

    logic [NUM_REQ-1:0]    rd_elig;
    logic [NUM_REQ-1:0]    wr_elig;
    logic                  rd_found;
    logic [ID_NBITS-1:0]   rd_win;
    logic                  wr_found;
    logic [ID_NBITS-1:0]   wr_win;
    logic                  s0_vld;
    logic [ADDR_NBITS-1:0] s0_addr;

    // NUM_REQ is a power of two, so pointer arithmetic wraps naturally in ID_NBITS bits.
    function automatic logic [ID_NBITS:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                  input logic [ID_NBITS-1:0] ptr);
        logic                found;
        logic [ID_NBITS-1:0] win;
        logic [ID_NBITS-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + ID_NBITS'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_a[i] = req_addr[i*ADDR_NBITS +: ADDR_NBITS];
        end
    end

    // The current-cycle atomic (S0) needs no read-side check: the read arbiter grants one per cycle.
    always_comb begin
        rd_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_elig[i] = rstn && req[i] && (req_atomic[i] || !req_wr[i])
                         && !(s1_vld_q && (addr_a[i] == s1_addr_q));
        end
    end

    always_comb begin
        {rd_found, rd_win} = rr_pick(rd_elig, rd_ptr_q);
    end

    assign s0_vld  = rd_found && req_atomic[rd_win];
    assign s0_addr = addr_a[rd_win];

    // A valid S2 owns the write port, which freezes the whole write arbiter.
    always_comb begin
        wr_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_elig[i] = rstn && !s2_vld_q && req[i] && !req_atomic[i] && req_wr[i]
                         && !(s0_vld && (addr_a[i] == s0_addr))
                         && !(s1_vld_q && (addr_a[i] == s1_addr_q));
        end
    end

    always_comb begin
        {wr_found, wr_win} = rr_pick(wr_elig, wr_ptr_q);
    end

    always_comb begin
        rd_en   = rd_found;
        rd_addr = rd_found ? addr_a[rd_win] : '0;
        rd_sel  = rd_found ? rd_win : '0;
        wr_en   = 1'b0;
        wr_wb   = 1'b0;
        wr_addr = '0;
        wr_sel  = '0;
        if (s2_vld_q) begin
            wr_en   = 1'b1;
            wr_wb   = 1'b1;
            wr_addr = s2_addr_q;
            wr_sel  = s2_id_q;
        end else if (wr_found) begin
            wr_en   = 1'b1;
            wr_addr = addr_a[wr_win];
            wr_sel  = wr_win;
        end
    end

    assign gnt = gnt_q;

    always_comb begin
        gnt_d = '0;
        if (rd_found) begin
            gnt_d[rd_win] = 1'b1;
        end
        if (wr_found) begin
            gnt_d[wr_win] = 1'b1;
        end
        rd_ptr_d  = rd_found ? rd_win + 1'b1 : rd_ptr_q;
        wr_ptr_d  = wr_found ? wr_win + 1'b1 : wr_ptr_q;
        s1_vld_d  = s0_vld;
        s1_addr_d = s0_vld ? s0_addr : '0;
        s1_id_d   = s0_vld ? rd_win  : '0;
        s2_vld_d  = s1_vld_q;
        s2_addr_d = s1_addr_q;
        s2_id_d   = s1_id_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_id_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_id_q   <= '0;
        end else begin
            gnt_q     <= gnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s1_id_q   <= s1_id_d;
            s2_vld_q  <= s2_vld_d;
            s2_addr_q <= s2_addr_d;
            s2_id_q   <= s2_id_d;
        end
    end

endmodule

// File: tb/tb_pu_rmw_sched.sv
// Bench for pu_rmw_sched: directed scenarios and random traffic checked every cycle
// against a reference model that tracks atomics by their age in cycles.
module tb_pu_rmw_sched;

    localparam int N  = 8;
    localparam int AW = 12;
    localparam int IW = 3;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N-1:0]    req_wr;
    logic [N-1:0]    req_atomic;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [IW-1:0]   rd_sel;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [IW-1:0]   wr_sel;
    logic            wr_wb;

    pu_rmw_sched #(.NUM_REQ(N), .ADDR_NBITS(AW), .ID_NBITS(IW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .req_wr     (req_wr),
        .req_atomic (req_atomic),
        .req_addr   (req_addr),
        .gnt        (gnt),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_sel     (rd_sel),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_sel     (wr_sel),
        .wr_wb      (wr_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int id;
        int t;
    } atom_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         m_rd_ptr = 0;
    int         m_wr_ptr = 0;
    logic [N-1:0] m_gnt = '0;
    atom_t      hist[$];

    logic [N-1:0]  o_gnt;
    logic          o_rd_en, o_wr_en, o_wr_wb;
    logic [AW-1:0] o_rd_addr, o_wr_addr;
    logic [IW-1:0] o_rd_sel, o_wr_sel;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int a_of(int i);
        return int'(req_addr[i*AW +: AW]);
    endfunction

    function automatic bit locked(int a, int lo, int hi);
        foreach (hist[j]) begin
            if (hist[j].addr == a && (cyc - hist[j].t) >= lo && (cyc - hist[j].t) <= hi) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic set_req(int i, bit r, bit w, bit a, int addr);
        req[i]        = r;
        req_wr[i]     = w;
        req_atomic[i] = a;
        req_addr[i*AW +: AW] = AW'(addr);
    endtask

    task automatic clear_reqs();
        req = '0; req_wr = '0; req_atomic = '0; req_addr = '0;
    endtask

    // One clock cycle: sample at the falling edge, compare with the model, advance the model.
    task automatic step();
        int rw, ww, wbi;
        int e_rd_en, e_rd_addr, e_rd_sel, e_wr_en, e_wr_addr, e_wr_sel, e_wr_wb;
        @(negedge clk);
        o_gnt = gnt; o_rd_en = rd_en; o_rd_addr = rd_addr; o_rd_sel = rd_sel;
        o_wr_en = wr_en; o_wr_addr = wr_addr; o_wr_sel = wr_sel; o_wr_wb = wr_wb;
        rw = -1; ww = -1; wbi = -1;
        e_rd_en = 0; e_rd_addr = 0; e_rd_sel = 0;
        e_wr_en = 0; e_wr_addr = 0; e_wr_sel = 0; e_wr_wb = 0;
        if (!rstn) m_gnt = '0;
        if (rstn) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rd_ptr + k) % N;
                if (rw < 0 && req[i] && (req_atomic[i] || !req_wr[i]) && !locked(a_of(i), 1, 1)) rw = i;
            end
            foreach (hist[j]) if (cyc - hist[j].t == 2) wbi = j;
            if (wbi < 0) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_wr_ptr + k) % N;
                    if (ww < 0 && req[i] && !req_atomic[i] && req_wr[i] && !locked(a_of(i), 1, 2)
                        && !(rw >= 0 && req_atomic[rw] && a_of(rw) == a_of(i))) ww = i;
                end
            end
            if (rw >= 0) begin
                e_rd_en = 1; e_rd_addr = a_of(rw); e_rd_sel = rw;
            end
            if (wbi >= 0) begin
                e_wr_en = 1; e_wr_wb = 1; e_wr_addr = hist[wbi].addr; e_wr_sel = hist[wbi].id;
            end else if (ww >= 0) begin
                e_wr_en = 1; e_wr_addr = a_of(ww); e_wr_sel = ww;
            end
        end
        chk("gnt",     32'(o_gnt),     32'(m_gnt));
        chk("rd_en",   32'(o_rd_en),   e_rd_en);
        chk("rd_addr", 32'(o_rd_addr), e_rd_addr);
        chk("rd_sel",  32'(o_rd_sel),  e_rd_sel);
        chk("wr_en",   32'(o_wr_en),   e_wr_en);
        chk("wr_addr", 32'(o_wr_addr), e_wr_addr);
        chk("wr_sel",  32'(o_wr_sel),  e_wr_sel);
        chk("wr_wb",   32'(o_wr_wb),   e_wr_wb);
        if (!rstn) begin
            m_rd_ptr = 0; m_wr_ptr = 0; m_gnt = '0;
            hist.delete();
        end else begin
            m_gnt = '0;
            if (rw >= 0) begin
                m_gnt[rw] = 1'b1;
                m_rd_ptr = (rw + 1) % N;
                if (req_atomic[rw]) hist.push_back('{a_of(rw), rw, cyc});
            end
            if (ww >= 0) begin
                m_gnt[ww] = 1'b1;
                m_wr_ptr = (ww + 1) % N;
            end
            for (int j = hist.size() - 1; j >= 0; j--) begin
                if (cyc - hist[j].t >= 2) hist.delete(j);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_reqs();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[4];
        int cnt[N];
        clear_reqs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step();
        chk("reset_gnt", 32'(o_gnt), 0);
        chk("reset_rd_en", 32'(o_rd_en), 0);
        rstn = 1'b1;

        // Three held reads rotate 0,1,2,0 with one-hot grant pulses
        do_reset();
        set_req(0, 1, 0, 0, 'h100);
        set_req(1, 1, 0, 0, 'h101);
        set_req(2, 1, 0, 0, 'h102);
        exp_seq = '{0, 1, 2, 0};
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rr_seq_sel", 32'(o_rd_sel), exp_seq[c]);
            if (c > 0) chk("rr_seq_gnt", 32'(o_gnt), 32'(1) << exp_seq[c-1]);
        end

        // Read behind an atomic to the same address waits for T+2
        do_reset();
        set_req(3, 1, 0, 1, 'h10);
        set_req(5, 1, 0, 0, 'h10);
        step();
        chk("atom_rd_T_sel", 32'(o_rd_sel), 3);
        set_req(3, 0, 0, 0, 'h10);
        step();
        chk("atom_rd_T1_en", 32'(o_rd_en), 0);
        step();
        chk("atom_rd_T2_sel", 32'(o_rd_sel), 5);
        chk("atom_rd_T2_wb", 32'(o_wr_wb), 1);
        chk("atom_rd_T2_waddr", 32'(o_wr_addr), 'h10);

        // Unrelated write proceeds at T and T+1 but yields to the writeback at T+2
        do_reset();
        set_req(4, 1, 0, 1, 'h20);
        set_req(1, 1, 1, 0, 'h44);
        step();
        chk("wr_bypass_T_sel", 32'(o_wr_sel), 1);
        chk("wr_bypass_T_wb", 32'(o_wr_wb), 0);
        set_req(4, 0, 0, 0, 'h20);
        step();
        chk("wr_bypass_T1_sel", 32'(o_wr_sel), 1);
        step();
        chk("wr_bypass_T2_wb", 32'(o_wr_wb), 1);
        chk("wr_bypass_T2_sel", 32'(o_wr_sel), 4);
        chk("wr_bypass_T2_waddr", 32'(o_wr_addr), 'h20);
        step();
        chk("wr_bypass_T3_gnt", 32'(o_gnt), 0);

        // Same-address write lands only after the writeback
        do_reset();
        set_req(3, 1, 0, 1, 'h30);
        set_req(2, 1, 1, 0, 'h30);
        step();
        chk("wr_block_T_en", 32'(o_wr_en), 0);
        set_req(3, 0, 0, 0, 'h30);
        step();
        chk("wr_block_T1_en", 32'(o_wr_en), 0);
        step();
        chk("wr_block_T2_sel", 32'(o_wr_sel), 3);
        step();
        chk("wr_block_T3_en", 32'(o_wr_en), 1);
        chk("wr_block_T3_sel", 32'(o_wr_sel), 2);
        chk("wr_block_T3_wb", 32'(o_wr_wb), 0);

        // Reset in the middle of an atomic drops its writeback
        do_reset();
        set_req(6, 1, 0, 1, 'h50);
        step();
        chk("rst_mid_T_sel", 32'(o_rd_sel), 6);
        clear_reqs();
        rstn = 1'b0;
        step();
        chk("rst_mid_T1_gnt", 32'(o_gnt), 0);
        rstn = 1'b1;
        set_req(2, 1, 0, 0, 'h51);
        set_req(6, 1, 0, 0, 'h52);
        step();
        chk("rst_mid_T2_wr_en", 32'(o_wr_en), 0);
        chk("rst_mid_T2_sel", 32'(o_rd_sel), 2);

        // Eight continuous writers each get one grant per eight cycles
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 1, 1, 0, 'h200 + i);
            cnt[i] = 0;
        end
        for (int c = 0; c < 17; c++) begin
            step();
            if (c > 0) for (int i = 0; i < N; i++) cnt[i] += int'(o_gnt[i]);
        end
        for (int i = 0; i < N; i++) chk("fair_wr_cnt", cnt[i], 2);

        // Random traffic over a small address set to provoke lock conflicts
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
            end
            rstn = ($urandom_range(0, 79) != 0);
            step();
        end
        rstn = 1'b1;
        clear_reqs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
